// File: rtl/imm_pkg.sv
// Shared constants for the immediate-extend stage: type codes, field geometry,
// and the prefix-tracking state type.
package imm_pkg;

  localparam logic [4:0] DT     = 5'b00000;
  localparam logic [4:0] AL     = 5'b00001;
  localparam logic [4:0] CT     = 5'b00010;
  localparam logic [4:0] PREFIX = 5'b00011;

  localparam int unsigned DT_LSB    = 6;
  localparam int unsigned DT_W      = 16;
  localparam int unsigned AL_LSB    = 0;
  localparam int unsigned AL_W      = 12;
  localparam int unsigned CT_LSB    = 0;
  localparam int unsigned CT_W      = 27;
  localparam int unsigned PAYLOAD_W = 27;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } prefix_state_t;

endpackage

// File: rtl/imm_field_extend.sv
// Combinational field select and extension. Builds a 64-bit signed result and
// narrows it to DATA_WIDTH, which covers both sign-extension and truncation.
module imm_field_extend
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [4:0]            imm_type,
  input  logic [31:0]           instruction,
  input  logic [PAYLOAD_W-1:0]  payload,
  input  logic                  prefix_active,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  prefixed
);

  logic [DT_W-1:0] dt_field;
  logic [AL_W-1:0] al_field;
  logic [CT_W-1:0] ct_field;
  logic [63:0]     wide;
  logic            pay_sign;

  assign dt_field = instruction[DT_LSB +: DT_W];
  assign al_field = instruction[AL_LSB +: AL_W];
  assign ct_field = instruction[CT_LSB +: CT_W];
  assign pay_sign = payload[PAYLOAD_W-1];

  // PREFIX itself never reaches the output register, so it shares the passthrough arm.
  always_comb begin
    wide     = {32'b0, instruction};
    prefixed = 1'b0;
    case (imm_type)
      DT: begin
        if (prefix_active) begin
          wide     = {{(64-PAYLOAD_W-DT_W){pay_sign}}, payload, dt_field};
          prefixed = 1'b1;
        end else begin
          wide = {{(64-DT_W){dt_field[DT_W-1]}}, dt_field};
        end
      end
      AL: begin
        if (prefix_active) begin
          wide     = {{(64-PAYLOAD_W-AL_W){pay_sign}}, payload, al_field};
          prefixed = 1'b1;
        end else begin
          wide = {{(64-AL_W){al_field[AL_W-1]}}, al_field};
        end
      end
      CT: begin
        if (prefix_active) begin
          wide     = {{(64-PAYLOAD_W-CT_W){pay_sign}}, payload, ct_field};
          prefixed = 1'b1;
        end else begin
          wide = {{(64-CT_W){ct_field[CT_W-1]}}, ct_field};
        end
      end
      default: begin
      end
    endcase
  end

  assign imm = DATA_WIDTH'(wide);

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-generation stage with valid/ready on both sides and flush.
// Define IMM_PREFIX_EN to compile in the PREFIX instruction and its payload FSM.
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [4:0]            out_type,
  output logic                  out_prefixed
);

  logic [4:0]            in_type;
  logic                  take;
  logic                  is_prefix;
  logic                  prefix_active;
  logic [PAYLOAD_W-1:0]  payload;
  logic [DATA_WIDTH-1:0] ext_imm;
  logic                  ext_prefixed;
  logic                  emit;

  assign in_type  = instruction[31:27];
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready && !flush;
  assign emit     = in_valid && !is_prefix;

`ifdef IMM_PREFIX_EN
  prefix_state_t state;

  assign is_prefix     = (in_type == PREFIX);
  assign prefix_active = (state == ARMED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      payload <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (take) begin
      if (is_prefix) begin
        payload <= instruction[PAYLOAD_W-1:0];
        state   <= ARMED;
      end else begin
        state <= IDLE;
      end
    end
  end
`else
  assign is_prefix     = 1'b0;
  assign prefix_active = 1'b0;
  assign payload       = '0;
`endif

  imm_field_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_extend (
    .imm_type      (in_type),
    .instruction   (instruction),
    .payload       (payload),
    .prefix_active (prefix_active),
    .imm           (ext_imm),
    .prefixed      (ext_prefixed)
  );

  // When the slot is free (or draining), a PREFIX or an idle input leaves it empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_type     <= '0;
      out_prefixed <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= emit;
      if (emit) begin
        out_imm      <= ext_imm;
        out_type     <= in_type;
        out_prefixed <= ext_prefixed;
      end
    end
  end

endmodule
